// File: rtl/gsim_pkg.sv
// Shared types, stencil constants and the saturation helper for the
// parametrised Gauss-Seidel solver.
package gsim_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, OUT} state_t;

    localparam int C1          = 13;
    localparam int C2          = 6;
    localparam int C3          = 1;
    localparam int RECIP20     = 52429;
    localparam int RECIP_SHIFT = 20;
    localparam int MAXW        = 128;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [MAXW-1:0] sat_signed(
        input logic signed [MAXW-1:0] v,
        input int                     w
    );
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = (MAXW'(1) <<< (w - 1)) - MAXW'(1);
        lo = -hi - MAXW'(1);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/gsim_row_update.sv
// Combinational single-row Gauss-Seidel update: x_new = S/20 (round half up),
// saturated to XW bits, plus |x_new - x_old| and a saturation flag.
module gsim_row_update
    import gsim_pkg::*;
#(
    parameter int BW   = 16,
    parameter int XW   = 32,
    parameter int FRAC = 16
) (
    input  logic signed [BW-1:0] b_i,
    input  logic signed [XW-1:0] x_old,
    input  logic signed [XW-1:0] nbr_x [6],
    input  logic        [5:0]    nbr_vld,
    output logic signed [XW-1:0] x_new,
    output logic        [XW:0]   delta,
    output logic                 sat
);
    localparam int SW = XW + BW + 6;
    localparam int PW = SW + 18;
    localparam logic signed [PW-1:0] ROUND = PW'(1) <<< (RECIP_SHIFT - 1);

    logic signed [SW-1:0]   nv [6];
    logic signed [SW-1:0]   s;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   quo;
    logic signed [MAXW-1:0] wide;
    logic signed [MAXW-1:0] clamped;
    logic signed [XW:0]     diff;

    // Neighbour order: {i-1, i+1, i-2, i+2, i-3, i+3}; invalid ones contribute zero.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_nv
            assign nv[gi] = nbr_vld[gi] ? SW'(nbr_x[gi]) : '0;
        end
    endgenerate

    always_comb begin
        s = (SW'(b_i) <<< FRAC)
          + SW'(C1) * (nv[0] + nv[1])
          - SW'(C2) * (nv[2] + nv[3])
          + SW'(C3) * (nv[4] + nv[5]);
        prod    = PW'(s) * PW'(RECIP20) + ROUND;
        quo     = prod >>> RECIP_SHIFT;
        wide    = MAXW'(quo);
        clamped = sat_signed(wide, XW);
        sat     = (clamped != wide);
        x_new   = clamped[XW-1:0];
        diff    = (XW+1)'(x_new) - (XW+1)'(x_old);
        delta   = diff[XW] ? $unsigned(-diff) : $unsigned(diff);
    end

endmodule

// File: rtl/gsim_param.sv
// Gauss-Seidel solver top: loads N b values, sweeps in place over the x
// register file until converged or capped, then streams the N results.
module gsim_param
    import gsim_pkg::*;
#(
    parameter int N    = 16,
    parameter int BW   = 16,
    parameter int XW   = 32,
    parameter int FRAC = 16,
    parameter int ITW  = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_en,
    input  logic [BW-1:0]  b_in,
    input  logic           warm_start,
    input  logic [ITW-1:0] max_iter,
    input  logic [XW-1:0]  tol,
    output logic           busy,
    output logic           out_valid,
    output logic [XW-1:0]  x_out,
    output logic [ITW-1:0] iter_cnt
);
    localparam int IW = $clog2(N);

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [ITW-1:0]        iter_q, iter_d, iter_inc;
    logic [ITW-1:0]        max_iter_q, max_iter_d;
    logic [XW-1:0]         tol_q, tol_d;
    logic                  warm_q, warm_d;
    logic [XW:0]           max_delta_q, max_delta_d, md_now;
    logic                  sat_seen_q, sat_seen_d, sat_now;
    logic signed [BW-1:0]  b_q [N];
    logic signed [BW-1:0]  b_d [N];
    logic signed [XW-1:0]  x_q [N];
    logic signed [XW-1:0]  x_d [N];
    logic                  out_valid_q, out_valid_d;
    logic [XW-1:0]         x_out_q, x_out_d;

    logic signed [XW-1:0]  nbr_x [6];
    logic [5:0]            nbr_vld;
    logic signed [XW-1:0]  upd_x;
    logic [XW:0]           upd_delta;
    logic                  upd_sat;

    // Neighbour taps read the live x registers, so rows below idx are already new.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_nbr
            localparam int OFF = (gi % 2 == 0) ? -(gi / 2 + 1) : (gi / 2 + 1);
            int j;
            assign j           = int'(idx_q) + OFF;
            assign nbr_vld[gi] = (j >= 0) && (j < N);
            assign nbr_x[gi]   = nbr_vld[gi] ? x_q[j[IW-1:0]] : '0;
        end
    endgenerate

    gsim_row_update #(
        .BW   (BW),
        .XW   (XW),
        .FRAC (FRAC)
    ) u_row (
        .b_i     (b_q[idx_q]),
        .x_old   (x_q[idx_q]),
        .nbr_x   (nbr_x),
        .nbr_vld (nbr_vld),
        .x_new   (upd_x),
        .delta   (upd_delta),
        .sat     (upd_sat)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        iter_d      = iter_q;
        max_iter_d  = max_iter_q;
        tol_d       = tol_q;
        warm_d      = warm_q;
        max_delta_d = max_delta_q;
        sat_seen_d  = sat_seen_q;
        b_d         = b_q;
        x_d         = x_q;
        out_valid_d = 1'b0;
        x_out_d     = '0;
        iter_inc    = iter_q + 1'b1;
        md_now      = (upd_delta > max_delta_q) ? upd_delta : max_delta_q;
        sat_now     = sat_seen_q | upd_sat;

        case (state_q)
            IDLE: begin
                if (in_en) begin
                    b_d[0]     = b_in;
                    idx_d      = IW'(1);
                    iter_d     = '0;
                    max_iter_d = (max_iter == '0) ? ITW'(1) : max_iter;
                    tol_d      = tol;
                    warm_d     = warm_start;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (in_en) begin
                    b_d[idx_q] = b_in;
                    if (idx_q == IW'(N - 1)) begin
                        idx_d       = '0;
                        max_delta_d = '0;
                        sat_seen_d  = 1'b0;
                        state_d     = SWEEP;
                        if (!warm_q) begin
                            for (int k = 0; k < N; k++) begin
                                x_d[k] = '0;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SWEEP: begin
                x_d[idx_q] = upd_x;
                if (idx_q == IW'(N - 1)) begin
                    iter_d      = iter_inc;
                    idx_d       = '0;
                    max_delta_d = '0;
                    sat_seen_d  = 1'b0;
                    // A saturated row never counts as converged, whatever tol says.
                    if ((!sat_now && (md_now <= {1'b0, tol_q})) || (iter_inc == max_iter_q)) begin
                        state_d = OUT;
                    end
                end else begin
                    idx_d       = idx_q + 1'b1;
                    max_delta_d = md_now;
                    sat_seen_d  = sat_now;
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                x_out_d     = x_q[idx_q];
                if (idx_q == IW'(N - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            iter_q      <= '0;
            max_iter_q  <= '0;
            tol_q       <= '0;
            warm_q      <= 1'b0;
            max_delta_q <= '0;
            sat_seen_q  <= 1'b0;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            for (int k = 0; k < N; k++) begin
                b_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            iter_q      <= iter_d;
            max_iter_q  <= max_iter_d;
            tol_q       <= tol_d;
            warm_q      <= warm_d;
            max_delta_q <= max_delta_d;
            sat_seen_q  <= sat_seen_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
            b_q         <= b_d;
            x_q         <= x_d;
        end
    end

    // The last output beat is registered, so busy also covers it after state returns to IDLE.
    assign busy      = (state_q != IDLE) || out_valid_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_gsim_param.sv
// Self-checking bench for gsim_param: directed and random problems compared
// against a plain-arithmetic Gauss-Seidel reference model.
module tb_gsim_param;
    localparam int N    = 16;
    localparam int BW   = 16;
    localparam int XW   = 32;
    localparam int FRAC = 16;
    localparam int ITW  = 10;
    localparam longint XMAX = 64'sd2147483647;
    localparam longint XMIN = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_en;
    logic [BW-1:0]  b_in;
    logic           warm_start;
    logic [ITW-1:0] max_iter;
    logic [XW-1:0]  tol;
    logic           busy;
    logic           out_valid;
    logic [XW-1:0]  x_out;
    logic [ITW-1:0] iter_cnt;

    int     checks = 0;
    int     errors = 0;
    longint bv [N];
    longint mx [N];
    int     m_iter;

    always #5 clk = ~clk;

    gsim_param #(.N(N), .BW(BW), .XW(XW), .FRAC(FRAC), .ITW(ITW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_en      (in_en),
        .b_in       (b_in),
        .warm_start (warm_start),
        .max_iter   (max_iter),
        .tol        (tol),
        .busy       (busy),
        .out_valid  (out_valid),
        .x_out      (x_out),
        .iter_cnt   (iter_cnt)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [63:0] obs, input longint tgt, input longint tolr);
        checks++;
        assert (obs >= tgt - tolr && obs <= tgt + tolr) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, tgt, tolr);
        end
    endtask

    function automatic longint coef(input int d);
        return (d == 1) ? 64'sd13 : ((d == 2) ? -64'sd6 : 64'sd1);
    endfunction

    // Reference: row-by-row Gauss-Seidel on integers, S/20 via the reciprocal with round-half-up.
    task automatic model(input bit warm, input int maxit, input longint tolv);
        longint s, xn, d, maxd;
        bit     sat;
        int     lim;
        if (!warm) foreach (mx[i]) mx[i] = 0;
        lim    = (maxit == 0) ? 1 : maxit;
        m_iter = 0;
        do begin
            maxd = 0;
            sat  = 1'b0;
            for (int i = 0; i < N; i++) begin
                s = bv[i] * (64'sd1 <<< FRAC);
                for (int dd = 1; dd <= 3; dd++) begin
                    if (i - dd >= 0) s += coef(dd) * mx[i - dd];
                    if (i + dd < N)  s += coef(dd) * mx[i + dd];
                end
                xn = (s * 52429 + 524288) >>> 20;
                if (xn > XMAX) begin xn = XMAX; sat = 1'b1; end
                else if (xn < XMIN) begin xn = XMIN; sat = 1'b1; end
                d = xn - mx[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                mx[i] = xn;
            end
            m_iter++;
        end while (!((!sat && maxd <= tolv) || m_iter == lim));
    endtask

    task automatic load(input bit warm, input int maxit, input longint tolv, input int gap);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_en = 1'b1;
            b_in  = BW'(bv[k]);
            if (k == 0) begin
                warm_start = warm;
                max_iter   = ITW'(maxit);
                tol        = XW'(tolv);
            end else begin
                warm_start = 1'($urandom);
                max_iter   = ITW'($urandom);
                tol        = XW'($urandom);
            end
            if (k < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_en = 1'b0;
                    b_in  = BW'($urandom);
                end
            end
        end
        @(posedge clk);
        #1;
        in_en = 1'b0;
    endtask

    task automatic collect(input string name, input bit near_chk, input longint target);
        int lat;
        lat = 0;
        // Stray in_en pulses while sweeping must be ignored.
        while (out_valid !== 1'b1 && lat < m_iter * N + 40) begin
            in_en = 1'($urandom);
            b_in  = BW'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_en = 1'b0;
        check({name, ".latency"}, lat, m_iter * N + 1);
        check({name, ".iter_cnt"}, iter_cnt, m_iter);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.valid[%0d]", name, i), out_valid, 1);
            check($sformatf("%s.busy[%0d]", name, i), busy, 1);
            check($sformatf("%s.x[%0d]", name, i), $signed(x_out), mx[i]);
            if (near_chk) check_near($sformatf("%s.near[%0d]", name, i), $signed(x_out), target, 4);
            @(posedge clk);
            #1;
        end
        check({name, ".valid_end"}, out_valid, 0);
        check({name, ".busy_end"}, busy, 0);
        $display("%s: iter_cnt=%0d latency=%0d x0=%0d", name, iter_cnt, lat, mx[0]);
    endtask

    task automatic set_ones(input longint sgn);
        longint ones_b [N];
        ones_b = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
        foreach (bv[i]) bv[i] = sgn * ones_b[i];
    endtask

    initial begin
        int maxit;
        bit warm;
        longint tolv;

        reset = 1'b1; in_en = 1'b0; b_in = '0;
        warm_start = 1'b0; max_iter = '0; tol = '0;
        #12;
        check("rst.busy", busy, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.x_out", x_out, 0);
        check("rst.iter_cnt", iter_cnt, 0);
        reset = 1'b0;
        foreach (mx[i]) mx[i] = 0;

        foreach (bv[i]) bv[i] = 0;
        model(1'b0, 10, 0);
        load(1'b0, 10, 0, 0);
        collect("zero", 1'b1, 0);

        set_ones(1);
        model(1'b0, 3, 0);
        load(1'b0, 3, 0, 0);
        collect("cap", 1'b0, 0);

        model(1'b0, 1023, 1);
        load(1'b0, 1023, 1, 0);
        collect("ones", 1'b1, 65536);

        model(1'b1, 1023, 4);
        load(1'b1, 1023, 4, 0);
        collect("warm", 1'b1, 65536);

        set_ones(-1);
        model(1'b0, 1023, 1);
        load(1'b0, 1023, 1, 0);
        collect("neg", 1'b1, -65536);

        for (int r = 0; r < 4; r++) begin
            foreach (bv[i]) bv[i] = longint'($urandom_range(0, 400)) - 200;
            warm  = 1'($urandom);
            maxit = int'($urandom_range(0, 6));
            tolv  = longint'($urandom_range(0, 2000));
            model(warm, maxit, tolv);
            load(warm, maxit, tolv, int'($urandom_range(0, 1)));
            collect($sformatf("rand%0d", r), 1'b0, 0);
        end

        // Asynchronous reset in the middle of a sweep discards the problem and clears x.
        set_ones(1);
        load(1'b1, 200, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        check("mid.busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid.busy", busy, 0);
        check("mid.out_valid", out_valid, 0);
        check("mid.x_out", x_out, 0);
        check("mid.iter_cnt", iter_cnt, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        foreach (mx[i]) mx[i] = 0;
        foreach (bv[i]) bv[i] = longint'($urandom_range(0, 400)) - 200;
        model(1'b1, 1023, 2);
        load(1'b1, 1023, 2, 2);
        collect("after_rst", 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gsim_param.md
Name: gsim_param

Overview:
- Parametrised Gauss-Seidel solver for the N-unknown symmetric banded system with row stencil [-1, 6, -13, 20, -13, 6, -1], i.e. M*x = b.
- Streams in N signed integer b values, then iterates in-place on a register-file copy of x. It stops on a runtime convergence tolerance or an iteration cap, then streams out N fixed-point x values.
- Successor to the fixed 16-unknown GSIM. It adds configurable size and widths, early termination, warm start and status outputs.

Parameters:
- N, 16, number of unknowns (min 4).
- BW, 16, b_in width, signed two's complement integer.
- XW, 32, x width, signed fixed point.
- FRAC, 16, fractional bits of x (Q(XW-FRAC).FRAC).
- ITW, 10, width of the iteration counter and max_iter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_en  in  1  b_in valid qualifier.
- b_in  in  BW  coefficient b_i, delivered in index order 0..N-1.
- warm_start  in  1  sampled on the first accepted b; 1 keeps the previous x as the initial guess, 0 clears x to zero.
- max_iter  in  ITW  sweep cap, sampled on the first accepted b; 0 is treated as 1.
- tol  in  XW  convergence threshold in x LSBs, sampled on the first accepted b.
- busy  out  1  high from the first accepted b until the last output beat.
- out_valid  out  1  x_out valid.
- x_out  out  XW  x_i, delivered in index order 0..N-1.
- iter_cnt  out  ITW  sweeps executed for the current or last problem.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; x regs, counters and iter_cnt cleared; busy=0, out_valid=0, x_out=0. An in-flight problem is discarded.
- FSM states:
  - IDLE -> LOAD on the first in_en. This edge samples warm_start, max_iter and tol, and stores b_0.
  - LOAD: stores one b per in_en cycle. Gaps in in_en are allowed (counter holds). Goes to SWEEP after b_{N-1}.
  - SWEEP: updates exactly one unknown per cycle, index 0..N-1. Each update reads the current x registers, so updated lower neighbours are used (true Gauss-Seidel). One sweep = N cycles. At sweep end, iter_cnt is incremented. Goes to OUT if max_delta<=tol or iter_cnt==max_iter; otherwise starts the next sweep.
  - OUT: out_valid=1 for exactly N consecutive cycles with x_0..x_{N-1}, then returns to IDLE and busy=0.
- in_en outside IDLE/LOAD is ignored; its b_in is dropped with no error.
- Row update for index i:
  - S = (b_i << FRAC) + 13*(x_{i-1}+x_{i+1}) - 6*(x_{i-2}+x_{i+2}) + (x_{i-3}+x_{i+3}).
  - Neighbour indices outside 0..N-1 contribute 0.
  - S is computed at width XW+BW+6, signed.
  - x_new = (S*52429 + 2^19) >>> 20, i.e. S/20 with round-half-up; 52429 = round(2^20/20).
  - x_new saturates to the signed XW range.
- Convergence: delta_i = |x_new - x_old|. max_delta is reset at the start of each sweep and holds the running maximum over the sweep. Saturated deltas compare as greater than any tol.
- Latency from the last b to the first out_valid: iter_cnt*N + 1 cycles. Minimum total busy time is 3N cycles.
- warm_start=0 clears all x before the first sweep (taken within the LOAD->SWEEP transition, no extra cycle).

Decomposition:
- Shared package gsim_pkg holds:
  - FSM state enum {IDLE, LOAD, SWEEP, OUT};
  - stencil constants C1=13, C2=6, C3=1;
  - RECIP20=52429, RECIP_SHIFT=20;
  - the saturation helper function.
- One sub-module, gsim_row_update: combinational. Takes b_i, x_old and six neighbours with validity masks; returns x_new, delta and a sat flag.
- The top level holds the FSM, the b/x register files, the counters and the output mux.

Test Plan:
- All-ones solution, N=16, b={12,-1,5,4,4,4,4,4,4,4,4,4,4,5,-1,12}, tol=1, max_iter=1023 -> every x_out within 0x00010000±4, iter_cnt<1023, out_valid high for exactly 16 cycles.
- Negated vector (b={-12,1,-5,-4,...,-4,-5,1,-12}) -> every x_out within 0xFFFF0000±4.
- b all zero, warm_start=0, tol=0 -> converges after 1 sweep: iter_cnt=1, all x_out=0, first out_valid 17 cycles after the last b.
- Iteration cap: the all-ones b with tol=0, max_iter=3 -> iter_cnt=3, first out_valid exactly 49 cycles after the last b.
- Warm start: rerun the converged all-ones problem with warm_start=1, tol=4 -> iter_cnt=1, outputs unchanged ±4 LSB.
- Reset asserted mid-SWEEP for 1 cycle (async, between edges) -> busy, out_valid and x_out drop immediately and iter_cnt=0. A new full problem then solves correctly, with in_en gaps of 2 cycles inserted during LOAD.
